// File: rtl/core_types_pkg.sv
// Shared rename/ROB/checkpoint types used by the free-list controller and its neighbours.
package core_types_pkg;

   localparam int unsigned PHYS_REG_TAG_W   = 7;
   localparam int unsigned ROB_INDEX_W      = 7;
   localparam int unsigned CHECKPOINT_COL_W = 3;

   typedef logic [PHYS_REG_TAG_W-1:0]   phys_reg_tag_t;
   typedef logic [ROB_INDEX_W-1:0]      ROB_index_t;
   typedef logic [CHECKPOINT_COL_W-1:0] checkpoint_column_t;

   // Payload of a buffered branch resolve request
   typedef struct packed {
      logic               failed;
      ROB_index_t         rob_index;
      checkpoint_column_t column;
   } branch_restore_req_t;

endpackage

// File: rtl/phys_reg_free_list_ctrl.sv
// Arbitrates rename, checkpoint save, commit free, ROB revert and branch restore onto the free list.
// Optional saturating statistics counters are enabled with `define FREE_LIST_CTRL_STATS_EN.
module phys_reg_free_list_ctrl
   import core_types_pkg::*;
#(
   parameter int unsigned STATS_W = 16
) (
   input  logic               CLK,
   input  logic               nRST,
   // dispatch
   input  logic               dispatch_rename_req,
   output logic               dispatch_rename_ready,
   output phys_reg_tag_t      dispatch_rename_tag,
   input  logic               dispatch_save_req,
   input  ROB_index_t         dispatch_save_ROB_index,
   output logic               dispatch_save_ready,
   output checkpoint_column_t dispatch_save_column,
   // commit, ROB revert, branch
   input  logic               commit_free_valid,
   input  phys_reg_tag_t      commit_free_tag,
   input  logic               rob_revert_valid,
   input  phys_reg_tag_t      rob_revert_tag,
   input  logic               rob_revert_done,
   input  logic               branch_restore_valid,
   input  logic               branch_restore_failed,
   input  ROB_index_t         branch_restore_ROB_index,
   input  checkpoint_column_t branch_restore_column,
   output logic               branch_restore_ready,
   output logic               branch_resp_valid,
   output logic               branch_resp_success,
   // free list
   output logic               fl_dequeue_valid,
   input  phys_reg_tag_t      fl_dequeue_tag,
   output logic               fl_enqueue_valid,
   output phys_reg_tag_t      fl_enqueue_tag,
   input  logic               fl_empty,
   output logic               fl_revert_valid,
   output phys_reg_tag_t      fl_revert_tag,
   output logic               fl_save_valid,
   output ROB_index_t         fl_save_ROB_index,
   input  checkpoint_column_t fl_save_column,
   output logic               fl_restore_valid,
   output logic               fl_restore_failed,
   output ROB_index_t         fl_restore_ROB_index,
   output checkpoint_column_t fl_restore_column,
   input  logic               fl_restore_success
`ifdef FREE_LIST_CTRL_STATS_EN
   ,
   output logic [STATS_W-1:0] stat_empty_stall,
   output logic [STATS_W-1:0] stat_revert_cycles
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REVERT  = 2'd1,
      ST_RECOVER = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                buf_valid_q, buf_valid_d;
   branch_restore_req_t buf_q, buf_d;

   logic failed_issue_c;
   logic restore_issue_c;
   logic idle_free_c;
   logic save_grant_c;
   logic rename_grant_c;
   logic restore_ready_c;

   if (STATS_W == 0) begin : g_stats_w_chk
      $error("STATS_W must be at least 1");
   end

   // Single-issue arbitration: revert > failed restore > save > dequeue
   always_comb begin
      failed_issue_c  = buf_valid_q & buf_q.failed & ~rob_revert_valid;
      restore_issue_c = buf_valid_q & (~buf_q.failed | ~rob_revert_valid);
      idle_free_c     = (state_q == ST_IDLE) & ~rob_revert_valid & ~failed_issue_c;
      save_grant_c    = idle_free_c & dispatch_save_req;
      rename_grant_c  = idle_free_c & ~save_grant_c & dispatch_rename_req & ~fl_empty;
      restore_ready_c = ~buf_valid_q | restore_issue_c;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (rob_revert_valid) state_d = ST_REVERT;
         ST_REVERT:  if (rob_revert_done)  state_d = ST_IDLE;
         ST_RECOVER: state_d = rob_revert_valid ? ST_REVERT : ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
      // A mispredict recovery overrides whatever the walk was doing
      if (failed_issue_c) state_d = ST_RECOVER;
   end

   // One-entry branch request buffer; a new request may refill it in its drain cycle
   always_comb begin
      buf_valid_d = buf_valid_q;
      buf_d       = buf_q;
      if (branch_restore_valid && restore_ready_c) begin
         buf_valid_d     = 1'b1;
         buf_d.failed    = branch_restore_failed;
         buf_d.rob_index = branch_restore_ROB_index;
         buf_d.column    = branch_restore_column;
      end else if (restore_issue_c) begin
         buf_valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         buf_valid_q <= 1'b0;
         buf_q       <= '0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_q       <= buf_d;
      end
   end

   // Outputs; data fields read zero whenever their valid is low
   always_comb begin
      dispatch_rename_ready = rename_grant_c;
      dispatch_rename_tag   = '0;
      dispatch_save_ready   = save_grant_c;
      dispatch_save_column  = '0;
      fl_dequeue_valid      = rename_grant_c;
      fl_save_valid         = save_grant_c;
      fl_save_ROB_index     = '0;
      fl_enqueue_valid      = commit_free_valid & (commit_free_tag != '0);
      fl_enqueue_tag        = '0;
      fl_revert_valid       = rob_revert_valid;
      fl_revert_tag         = '0;
      fl_restore_valid      = restore_issue_c;
      fl_restore_failed     = restore_issue_c & buf_q.failed;
      fl_restore_ROB_index  = '0;
      fl_restore_column     = '0;
      branch_restore_ready  = restore_ready_c;
      branch_resp_valid     = restore_issue_c;
      branch_resp_success   = restore_issue_c & fl_restore_success;
      if (rename_grant_c) dispatch_rename_tag = fl_dequeue_tag;
      if (save_grant_c) begin
         dispatch_save_column = fl_save_column;
         fl_save_ROB_index    = dispatch_save_ROB_index;
      end
      if (fl_enqueue_valid) fl_enqueue_tag = commit_free_tag;
      if (rob_revert_valid) fl_revert_tag = rob_revert_tag;
      if (restore_issue_c) begin
         fl_restore_ROB_index = buf_q.rob_index;
         fl_restore_column    = buf_q.column;
      end
   end

`ifdef FREE_LIST_CTRL_STATS_EN
   logic [STATS_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [STATS_W-1:0] revert_cnt_q, revert_cnt_d;

   // Saturating event counters
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      revert_cnt_d = revert_cnt_q;
      if (dispatch_rename_req && fl_empty && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + STATS_W'(1);
      if ((state_q == ST_REVERT) && (revert_cnt_q != '1))
         revert_cnt_d = revert_cnt_q + STATS_W'(1);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt_q  <= '0;
         revert_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         revert_cnt_q <= revert_cnt_d;
      end
   end

   assign stat_empty_stall   = stall_cnt_q;
   assign stat_revert_cycles = revert_cnt_q;
`endif

endmodule

// File: tb/tb_phys_reg_free_list_ctrl.sv
// Directed + randomized bench for phys_reg_free_list_ctrl against a rule-level reference model.
module tb_phys_reg_free_list_ctrl;
   import core_types_pkg::*;

   logic               CLK, nRST;
   logic               dispatch_rename_req, dispatch_rename_ready;
   phys_reg_tag_t      dispatch_rename_tag;
   logic               dispatch_save_req, dispatch_save_ready;
   ROB_index_t         dispatch_save_ROB_index;
   checkpoint_column_t dispatch_save_column;
   logic               commit_free_valid;
   phys_reg_tag_t      commit_free_tag;
   logic               rob_revert_valid, rob_revert_done;
   phys_reg_tag_t      rob_revert_tag;
   logic               branch_restore_valid, branch_restore_failed;
   ROB_index_t         branch_restore_ROB_index;
   checkpoint_column_t branch_restore_column;
   logic               branch_restore_ready, branch_resp_valid, branch_resp_success;
   logic               fl_dequeue_valid, fl_enqueue_valid, fl_empty, fl_revert_valid;
   phys_reg_tag_t      fl_dequeue_tag, fl_enqueue_tag, fl_revert_tag;
   logic               fl_save_valid, fl_restore_valid, fl_restore_failed, fl_restore_success;
   ROB_index_t         fl_save_ROB_index, fl_restore_ROB_index;
   checkpoint_column_t fl_save_column, fl_restore_column;
`ifdef FREE_LIST_CTRL_STATS_EN
   logic [15:0]        stat_empty_stall, stat_revert_cycles;
`endif

   phys_reg_free_list_ctrl #(.STATS_W(16)) dut (
      .CLK(CLK), .nRST(nRST),
      .dispatch_rename_req(dispatch_rename_req), .dispatch_rename_ready(dispatch_rename_ready),
      .dispatch_rename_tag(dispatch_rename_tag), .dispatch_save_req(dispatch_save_req),
      .dispatch_save_ROB_index(dispatch_save_ROB_index), .dispatch_save_ready(dispatch_save_ready),
      .dispatch_save_column(dispatch_save_column),
      .commit_free_valid(commit_free_valid), .commit_free_tag(commit_free_tag),
      .rob_revert_valid(rob_revert_valid), .rob_revert_tag(rob_revert_tag),
      .rob_revert_done(rob_revert_done),
      .branch_restore_valid(branch_restore_valid), .branch_restore_failed(branch_restore_failed),
      .branch_restore_ROB_index(branch_restore_ROB_index), .branch_restore_column(branch_restore_column),
      .branch_restore_ready(branch_restore_ready), .branch_resp_valid(branch_resp_valid),
      .branch_resp_success(branch_resp_success),
      .fl_dequeue_valid(fl_dequeue_valid), .fl_dequeue_tag(fl_dequeue_tag),
      .fl_enqueue_valid(fl_enqueue_valid), .fl_enqueue_tag(fl_enqueue_tag), .fl_empty(fl_empty),
      .fl_revert_valid(fl_revert_valid), .fl_revert_tag(fl_revert_tag),
      .fl_save_valid(fl_save_valid), .fl_save_ROB_index(fl_save_ROB_index),
      .fl_save_column(fl_save_column),
      .fl_restore_valid(fl_restore_valid), .fl_restore_failed(fl_restore_failed),
      .fl_restore_ROB_index(fl_restore_ROB_index), .fl_restore_column(fl_restore_column),
      .fl_restore_success(fl_restore_success)
`ifdef FREE_LIST_CTRL_STATS_EN
      , .stat_empty_stall(stat_empty_stall), .stat_revert_cycles(stat_revert_cycles)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   localparam int M_IDLE = 0, M_REVERT = 1, M_RECOVER = 2;

   // Reference model: controller mode plus the contents of the pending-branch slot
   int  m_mode;
   bit  m_bv, m_bf;
   int  m_brob, m_bcol;
   int  m_stall, m_rev;
   bit  last_ready;
   bit  e_fail_go, e_rest_go, e_save, e_ren, e_ready;
   int  n_checks, n_fail;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_bv = 0; m_bf = 0; m_brob = 0; m_bcol = 0;
      m_stall = 0; m_rev = 0; last_ready = 1;
   endtask

   // What the rules say should happen this cycle, given current inputs
   task automatic predict();
      bit can_issue;
      e_fail_go = m_bv && m_bf && !rob_revert_valid;
      e_rest_go = m_bv && (!m_bf || !rob_revert_valid);
      can_issue = (m_mode == M_IDLE) && !rob_revert_valid && !e_fail_go;
      e_save    = can_issue && dispatch_save_req;
      e_ren     = can_issue && !e_save && dispatch_rename_req && !fl_empty;
      e_ready   = !m_bv || e_rest_go;
   endtask

   task automatic check_all();
      bit enq;
      enq = commit_free_valid && (commit_free_tag != 0);
      chk("rename_ready", 32'(dispatch_rename_ready), 32'(e_ren));
      chk("rename_tag", 32'(dispatch_rename_tag), e_ren ? 32'(fl_dequeue_tag) : 0);
      chk("fl_dequeue_valid", 32'(fl_dequeue_valid), 32'(e_ren));
      chk("save_ready", 32'(dispatch_save_ready), 32'(e_save));
      chk("save_column", 32'(dispatch_save_column), e_save ? 32'(fl_save_column) : 0);
      chk("fl_save_valid", 32'(fl_save_valid), 32'(e_save));
      chk("fl_save_rob", 32'(fl_save_ROB_index), e_save ? 32'(dispatch_save_ROB_index) : 0);
      chk("fl_enqueue_valid", 32'(fl_enqueue_valid), 32'(enq));
      chk("fl_enqueue_tag", 32'(fl_enqueue_tag), enq ? 32'(commit_free_tag) : 0);
      chk("fl_revert_valid", 32'(fl_revert_valid), 32'(rob_revert_valid));
      chk("fl_revert_tag", 32'(fl_revert_tag), rob_revert_valid ? 32'(rob_revert_tag) : 0);
      chk("fl_restore_valid", 32'(fl_restore_valid), 32'(e_rest_go));
      chk("fl_restore_failed", 32'(fl_restore_failed), 32'(e_rest_go && m_bf));
      chk("fl_restore_rob", 32'(fl_restore_ROB_index), e_rest_go ? 32'(m_brob) : 0);
      chk("fl_restore_col", 32'(fl_restore_column), e_rest_go ? 32'(m_bcol) : 0);
      chk("branch_ready", 32'(branch_restore_ready), 32'(e_ready));
      chk("resp_valid", 32'(branch_resp_valid), 32'(e_rest_go));
      chk("resp_success", 32'(branch_resp_success), 32'(e_rest_go && fl_restore_success));
`ifdef FREE_LIST_CTRL_STATS_EN
      chk("stat_empty_stall", 32'(stat_empty_stall), 32'(m_stall));
      chk("stat_revert_cycles", 32'(stat_revert_cycles), 32'(m_rev));
`endif
   endtask

   task automatic model_update();
      if (dispatch_rename_req && fl_empty && m_stall < 16'hFFFF) m_stall++;
      if (m_mode == M_REVERT && m_rev < 16'hFFFF) m_rev++;
      if (e_fail_go)                                 m_mode = M_RECOVER;
      else if (m_mode == M_IDLE && rob_revert_valid) m_mode = M_REVERT;
      else if (m_mode == M_REVERT && rob_revert_done) m_mode = M_IDLE;
      else if (m_mode == M_RECOVER)                  m_mode = rob_revert_valid ? M_REVERT : M_IDLE;
      if (branch_restore_valid && e_ready) begin
         m_bv = 1; m_bf = branch_restore_failed;
         m_brob = int'(branch_restore_ROB_index); m_bcol = int'(branch_restore_column);
      end else if (e_rest_go) begin
         m_bv = 0;
      end
      last_ready = e_ready;
   endtask

   task automatic settle();
      #2; predict(); check_all();
   endtask

   task automatic adv();
      @(posedge CLK); model_update(); #1;
   endtask

   task automatic clear_inputs();
      dispatch_rename_req = 0; dispatch_save_req = 0; dispatch_save_ROB_index = '0;
      commit_free_valid = 0; commit_free_tag = '0;
      rob_revert_valid = 0; rob_revert_tag = '0; rob_revert_done = 0;
      branch_restore_valid = 0; branch_restore_failed = 0;
      branch_restore_ROB_index = '0; branch_restore_column = '0;
      fl_dequeue_tag = '0; fl_empty = 0; fl_save_column = '0; fl_restore_success = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      nRST = 0; model_reset();
      settle();
      chk("rst_branch_ready", 32'(branch_restore_ready), 32'd1);
      chk("rst_resp_valid", 32'(branch_resp_valid), 32'd0);
      @(posedge CLK); #1;
      nRST = 1;
   endtask

   task automatic rand_inputs();
      if (!(branch_restore_valid && !last_ready)) begin
         branch_restore_valid     = ($urandom_range(0, 3) == 0);
         branch_restore_failed    = 1'($urandom_range(0, 1));
         branch_restore_ROB_index = ROB_index_t'($urandom);
         branch_restore_column    = checkpoint_column_t'($urandom);
      end
      dispatch_rename_req     = 1'($urandom_range(0, 1));
      dispatch_save_req       = ($urandom_range(0, 3) == 0);
      dispatch_save_ROB_index = ROB_index_t'($urandom);
      commit_free_valid       = 1'($urandom_range(0, 1));
      commit_free_tag         = ($urandom_range(0, 3) == 0) ? '0 : phys_reg_tag_t'($urandom);
      rob_revert_valid        = ($urandom_range(0, 9) < 3);
      rob_revert_tag          = phys_reg_tag_t'($urandom);
      rob_revert_done         = ($urandom_range(0, 3) == 0);
      fl_dequeue_tag          = phys_reg_tag_t'($urandom);
      fl_empty                = ($urandom_range(0, 3) == 0);
      fl_save_column          = checkpoint_column_t'($urandom);
      fl_restore_success      = 1'($urandom_range(0, 1));
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      nRST = 0; clear_inputs(); model_reset();
      #1;
      do_reset();

      // Basic rename grant
      clear_inputs();
      dispatch_rename_req = 1; fl_dequeue_tag = 7'h21;
      settle();
      chk("d_rename_ready", 32'(dispatch_rename_ready), 32'd1);
      chk("d_rename_tag", 32'(dispatch_rename_tag), 32'h21);
      chk("d_deq_valid", 32'(fl_dequeue_valid), 32'd1);
      adv();

      // Save beats rename, rename follows
      dispatch_save_req = 1; dispatch_save_ROB_index = 7'h05; fl_save_column = 3'd3;
      settle();
      chk("d_save_ready", 32'(dispatch_save_ready), 32'd1);
      chk("d_save_col", 32'(dispatch_save_column), 32'd3);
      chk("d_rename_blocked", 32'(dispatch_rename_ready), 32'd0);
      adv();
      dispatch_save_req = 0;
      settle();
      chk("d_rename_after_save", 32'(dispatch_rename_ready), 32'd1);
      adv();

      // Commit free: tag 0 dropped, tag 5 forwarded
      clear_inputs();
      commit_free_valid = 1; commit_free_tag = 7'h00;
      settle();
      chk("d_enq_zero", 32'(fl_enqueue_valid), 32'd0);
      adv();
      commit_free_tag = 7'h05;
      settle();
      chk("d_enq_valid", 32'(fl_enqueue_valid), 32'd1);
      chk("d_enq_tag", 32'(fl_enqueue_tag), 32'h05);
      adv();

      // Failed restore arriving during a 3-cycle revert walk
      clear_inputs();
      dispatch_rename_req = 1; fl_dequeue_tag = 7'h11;
      rob_revert_valid = 1; rob_revert_tag = 7'h30;
      branch_restore_valid = 1; branch_restore_failed = 1;
      branch_restore_ROB_index = 7'h44; branch_restore_column = 3'd6;
      settle();
      chk("d_w1_accept", 32'(branch_restore_ready), 32'd1);
      chk("d_w1_rename", 32'(dispatch_rename_ready), 32'd0);
      chk("d_w1_revert_tag", 32'(fl_revert_tag), 32'h30);
      adv();
      branch_restore_valid = 0;
      settle();
      chk("d_w2_held", 32'(fl_restore_valid), 32'd0);
      chk("d_w2_rename", 32'(dispatch_rename_ready), 32'd0);
      adv();
      rob_revert_done = 1;
      settle();
      chk("d_w3_held", 32'(fl_restore_valid), 32'd0);
      chk("d_w3_rename", 32'(dispatch_rename_ready), 32'd0);
      adv();
      rob_revert_valid = 0; rob_revert_done = 0;
      settle();
      chk("d_fail_issue", 32'(fl_restore_valid), 32'd1);
      chk("d_fail_flag", 32'(fl_restore_failed), 32'd1);
      chk("d_fail_rob", 32'(fl_restore_ROB_index), 32'h44);
      chk("d_fail_col", 32'(fl_restore_column), 32'd6);
      chk("d_fail_rename", 32'(dispatch_rename_ready), 32'd0);
      adv();
      settle();
      chk("d_recover_rename", 32'(dispatch_rename_ready), 32'd0);
      adv();
      settle();
      chk("d_post_recover_rename", 32'(dispatch_rename_ready), 32'd1);
      adv();

      // Non-failed restore with checkpoint hit
      clear_inputs();
      dispatch_rename_req = 1;
      branch_restore_valid = 1; branch_restore_ROB_index = 7'h12; branch_restore_column = 3'd2;
      settle();
      adv();
      branch_restore_valid = 0; fl_restore_success = 1;
      settle();
      chk("d_ok_resp_valid", 32'(branch_resp_valid), 32'd1);
      chk("d_ok_resp_success", 32'(branch_resp_success), 32'd1);
      chk("d_ok_rename", 32'(dispatch_rename_ready), 32'd1);
      adv();

      // Reset in the middle of a revert with a buffered failed restore
      clear_inputs();
      rob_revert_valid = 1; branch_restore_valid = 1; branch_restore_failed = 1;
      settle();
      adv();
      settle();
      chk("d_pre_rst_ready", 32'(branch_restore_ready), 32'd0);
      do_reset();
      clear_inputs();
      dispatch_rename_req = 1; fl_dequeue_tag = 7'h07;
      settle();
      chk("d_post_rst_ready", 32'(branch_restore_ready), 32'd1);
      chk("d_post_rst_rename", 32'(dispatch_rename_ready), 32'd1);
      adv();

      // Randomized traffic, with occasional asynchronous resets
      clear_inputs();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else begin
            rand_inputs();
            settle();
            adv();
         end
      end

`ifdef FREE_LIST_CTRL_STATS_EN
      do_reset();
      clear_inputs();
      dispatch_rename_req = 1; fl_empty = 1;
      for (int i = 0; i < 70000; i++) begin
         predict();
         adv();
      end
      settle();
      chk("d_stall_saturated", 32'(stat_empty_stall), 32'hFFFF);
      adv();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/phys_reg_free_list_ctrl.md
PHYS_REG_FREE_LIST_CTRL -- requirements
Module: phys_reg_free_list_ctrl

Interface
REQ-001 SHALL have parameter STATS_W, default 16, width of the saturating statistics counters.
REQ-002 SHALL have ports (types from core_types_pkg). Clock and reset:
- CLK  in  1  clock
- nRST  in  1  async active-low reset; reset is asynchronous and active-low, single clock CLK.
REQ-003 SHALL have dispatch ports:
- dispatch_rename_req  in  1  request a free phys reg
- dispatch_rename_ready  out  1  rename granted this cycle
- dispatch_rename_tag  out  phys_reg_tag_t  granted tag
- dispatch_save_req  in  1  request a checkpoint save
- dispatch_save_ROB_index  in  ROB_index_t  ROB index of the saving instr
- dispatch_save_ready  out  1  save granted
- dispatch_save_column  out  checkpoint_column_t  saved column
REQ-004 SHALL have commit, ROB revert and branch ports:
- commit_free_valid  in  1  free a phys reg
- commit_free_tag  in  phys_reg_tag_t  tag to free
- rob_revert_valid  in  1  revert one speculated mapping
- rob_revert_tag  in  phys_reg_tag_t  speculated tag
- rob_revert_done  in  1  revert walk complete
- branch_restore_valid  in  1  branch resolve request
- branch_restore_failed  in  1  mispredict
- branch_restore_ROB_index  in  ROB_index_t  checked tag
- branch_restore_column  in  checkpoint_column_t  safe column
- branch_restore_ready  out  1  request accepted
- branch_resp_valid  out  1  resolve response
- branch_resp_success  out  1  checkpoint hit
REQ-005 SHALL have free list side ports: fl_dequeue_valid out 1; fl_dequeue_tag in phys_reg_tag_t; fl_enqueue_valid out 1; fl_enqueue_tag out phys_reg_tag_t; fl_empty in 1; fl_revert_valid out 1; fl_revert_tag out phys_reg_tag_t; fl_save_valid out 1; fl_save_ROB_index out ROB_index_t; fl_save_column in checkpoint_column_t; fl_restore_valid out 1; fl_restore_failed out 1; fl_restore_ROB_index out ROB_index_t; fl_restore_column out checkpoint_column_t; fl_restore_success in 1.

Function
REQ-006 SHALL implement FSM states IDLE, REVERT, RECOVER.
REQ-007 SHALL transition IDLE->REVERT on rob_revert_valid; REVERT->IDLE on rob_revert_done; any state->RECOVER when a failed restore issues; RECOVER->IDLE after exactly 1 cycle, or ->REVERT if rob_revert_valid is high.
REQ-008 SHALL issue at most one of fl_revert/failed fl_restore/fl_save/fl_dequeue per cycle, with priority revert > failed restore > save > dequeue.
REQ-009 SHALL pass rob_revert_valid/tag combinationally to fl_revert_valid/tag in any state.
REQ-010 SHALL hold branch requests in a 1-entry buffer; branch_restore_ready = buffer empty, or buffer issuing this cycle.
REQ-011 SHALL issue the buffered non-failed restore in any cycle; SHALL issue a buffered failed restore only when rob_revert_valid is low. branch_resp_valid/success SHALL assert in the issue cycle, with success = fl_restore_success.
REQ-012 SHALL grant a save only in IDLE, with no revert or failed restore issuing; dispatch_save_column = fl_save_column.
REQ-013 SHALL grant a rename only in IDLE, with ~fl_empty and no higher-priority op this cycle; dispatch_rename_tag = fl_dequeue_tag.
REQ-014 SHALL forward commit_free to fl_enqueue unless the tag is 0, in which case it is dropped; SHALL not otherwise block enqueue.
REQ-015 SHALL hold pending requests unchanged when ready is low; requesters hold req until ready.

Reset
REQ-016 On nRST low, asynchronously: state IDLE; buffer empty; all outputs 0 except branch_restore_ready = 1; counters 0.
REQ-017 A reset mid-revert or mid-restore SHALL discard all pending state.

Configuration
REQ-018 With FREE_LIST_CTRL_STATS_EN defined, SHALL add outputs stat_empty_stall and stat_revert_cycles (STATS_W each, saturating at all-ones). These count cycles with rename_req and fl_empty, and cycles in REVERT, respectively. Without the macro, neither the ports nor the logic SHALL exist.

Verification
REQ-019 Reset then rename_req with fl_empty=0, fl_dequeue_tag=0x21 -> ready=1, tag=0x21, fl_dequeue_valid=1.
REQ-020 Save and rename requested in the same cycle -> save granted, rename ready=0; rename granted the next cycle.
REQ-021 commit_free tag 0x00 -> fl_enqueue_valid=0; tag 0x05 -> enqueue 0x05 in the same cycle.
REQ-022 Failed restore arrives during a 3-cycle revert walk -> held, issued the cycle after revert ends; RECOVER for 1 cycle; rename blocked throughout.
REQ-023 Non-failed restore, fl_restore_success=1 -> resp_valid=1, success=1 in the same cycle, no state change.
REQ-024 With the macro defined, 70000 empty-stall cycles -> stat_empty_stall=0xFFFF.
